ram_stream_reader: RTL and testbench

Read sequencer that sits directly downstream of the synchronous single-port `ram` (1-cycle registered read).
- Given a base address and a word count, it issues consecutive reads and captures the returned words.
- It streams the words out on a valid/ready interface, along with a lane index that drives the select of the downstream `mux_*_v2` stages.
- A 2-entry skid FIFO absorbs the RAM read latency so that downstream backpressure never loses or duplicates a word.

---
 rtl/ram_stream_reader_if.sv | 14 +
 rtl/ram_stream_reader.sv | 155 +++++++++++++++
 tb/tb_ram_stream_reader.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_stream_reader_if.sv
// Stream side of ram_stream_reader: data, lane index and last flag with a valid/ready handshake.
interface ram_stream_reader_if #(
  parameter int DATA_WIDTH = 32,
  parameter int SEL_WIDTH  = 4
);
  logic [DATA_WIDTH-1:0] o_data;
  logic                  o_valid;
  logic                  i_ready;
  logic                  o_last;
  logic [SEL_WIDTH-1:0]  o_sel;

  modport master (output o_data, output o_valid, output o_last, output o_sel, input i_ready);
  modport slave  (input o_data, input o_valid, input o_last, input o_sel, output i_ready);
endinterface

// File: rtl/ram_stream_reader.sv
// Issues consecutive reads to a 1-cycle-latency RAM and streams the words out through a
// 2-entry skid FIFO, so downstream backpressure never drops or repeats a word.
module ram_stream_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int SEL_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_base_addr,
  input  logic [ADDR_WIDTH:0]   i_len,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [ADDR_WIDTH-1:0] o_ram_addr,
  output logic                  o_ram_re,
  input  logic [DATA_WIDTH-1:0] i_ram_data,
  ram_stream_reader_if.master   strm
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  localparam logic [ADDR_WIDTH:0]  LEN_ONE = 1;
  localparam logic [SEL_WIDTH-1:0] SEL_ONE = 1;

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH:0]   len_q, len_d;
  logic [ADDR_WIDTH:0]   issueCnt_q, issueCnt_d;
  logic [ADDR_WIDTH:0]   emitCnt_q, emitCnt_d;
  logic [SEL_WIDTH-1:0]  sel_q, sel_d;
  logic                  done_q, done_d;
  logic                  inflight_q;

  logic [DATA_WIDTH-1:0] fifo_q [2];
  logic                  wrPtr_q, rdPtr_q;
  logic [1:0]            cnt_q;

  logic       valid, push, pop, issue, lastEmit;
  logic [2:0] occupancy;

  assign valid     = (cnt_q != 2'd0);
  assign push      = inflight_q;
  assign pop       = valid & strm.i_ready;
  assign lastEmit  = (emitCnt_q == (len_q - LEN_ONE));
  // Count the word already in flight so the FIFO can never be asked to hold a third entry.
  assign occupancy = {1'b0, cnt_q} + {2'b00, inflight_q};
  assign issue     = (state_q == RUN) && (issueCnt_q < len_q) &&
                     (occupancy < (3'd2 + {2'b00, pop}));

  assign o_ram_re   = issue;
  assign o_ram_addr = issue ? (base_q + issueCnt_q[ADDR_WIDTH-1:0]) : addr_q;
  assign o_busy     = (state_q != IDLE);
  assign o_done     = done_q;

  assign strm.o_valid = valid;
  assign strm.o_data  = fifo_q[rdPtr_q];
  assign strm.o_last  = valid & lastEmit;
  assign strm.o_sel   = sel_q;

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    len_d      = len_q;
    issueCnt_d = issueCnt_q;
    emitCnt_d  = emitCnt_q;
    sel_d      = sel_q;
    done_d     = 1'b0;

    if (pop) begin
      emitCnt_d = emitCnt_q + LEN_ONE;
      sel_d     = sel_q + SEL_ONE;
    end

    case (state_q)
      IDLE: begin
        if (i_start) begin
          if (i_len != '0) begin
            base_d     = i_base_addr;
            len_d      = i_len;
            issueCnt_d = '0;
            emitCnt_d  = '0;
            sel_d      = '0;
            state_d    = RUN;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (issue) begin
          issueCnt_d = issueCnt_q + LEN_ONE;
          if (issueCnt_q == (len_q - LEN_ONE)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && lastEmit) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      base_q     <= '0;
      len_q      <= '0;
      issueCnt_q <= '0;
      emitCnt_q  <= '0;
      sel_q      <= '0;
      done_q     <= 1'b0;
      addr_q     <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      len_q      <= len_d;
      issueCnt_q <= issueCnt_d;
      emitCnt_q  <= emitCnt_d;
      sel_q      <= sel_d;
      done_q     <= done_d;
      inflight_q <= issue;
      if (issue) addr_q <= o_ram_addr;
    end
  end

  // The RAM returns data one cycle after the read, so capture is keyed off the in-flight flag.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      wrPtr_q   <= 1'b0;
      rdPtr_q   <= 1'b0;
      cnt_q     <= 2'd0;
    end else begin
      if (push) begin
        fifo_q[wrPtr_q] <= i_ram_data;
        wrPtr_q         <= ~wrPtr_q;
      end
      if (pop) rdPtr_q <= ~rdPtr_q;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_stream_reader.sv
// Scoreboard bench for ram_stream_reader: stimulus queues expected addresses and words,
// a negedge monitor pops and compares them as the DUT presents reads and handshakes.
module tb_ram_stream_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  baseAddr;
  logic [4:0]  len;
  logic        busy, done;
  logic [3:0]  ramAddr;
  logic        ramRe;
  logic [31:0] ramData;
  logic [31:0] mem [16];

  ram_stream_reader_if #(.DATA_WIDTH(32), .SEL_WIDTH(2)) strm ();

  ram_stream_reader #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .SEL_WIDTH(2)) dut (
    .clk         (clk),
    .i_rst_n     (rst_n),
    .i_start     (start),
    .i_base_addr (baseAddr),
    .i_len       (len),
    .o_busy      (busy),
    .o_done      (done),
    .o_ram_addr  (ramAddr),
    .o_ram_re    (ramRe),
    .i_ram_data  (ramData),
    .strm        (strm)
  );

  always #5 clk = ~clk;

  always @(posedge clk) ramData <= mem[ramAddr];

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  sel;
    logic        last;
  } word_t;

  word_t      expQ[$];
  logic [3:0] addrQ[$];
  int         checks = 0;
  int         failures = 0;
  int         hsCount = 0;

  logic        held = 1'b0;
  logic [31:0] heldData;
  logic [1:0]  heldSel;
  logic        heldLast;
  word_t       w;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] b, input logic [4:0] l);
    @(posedge clk); #1;
    start = 1'b1; baseAddr = b; len = l;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic expectTransfer(input logic [3:0] b, input int l);
    logic [3:0] a;
    word_t      e;
    for (int i = 0; i < l; i++) begin
      a      = b + 4'(i);
      e.data = 32'(a) * 32'h11;
      e.sel  = 2'(i);
      e.last = (i == l - 1);
      addrQ.push_back(a);
      expQ.push_back(e);
    end
  endtask

  task automatic waitDone(input string name, input int maxCycles);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < maxCycles);
    checkOutput({name, "_done_seen"}, 32'(done), 32'd1);
    checkOutput({name, "_busy_with_done"}, 32'(busy), 32'd0);
    @(negedge clk);
    checkOutput({name, "_done_one_cycle"}, 32'(done), 32'd0);
    checkOutput({name, "_words_left"}, 32'(expQ.size()), 32'd0);
    checkOutput({name, "_reads_left"}, 32'(addrQ.size()), 32'd0);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      held = 1'b0;
    end else begin
      if (held) begin
        checkOutput("stall_valid", 32'(strm.o_valid), 32'd1);
        checkOutput("stall_data", strm.o_data, heldData);
        checkOutput("stall_sel", 32'(strm.o_sel), 32'(heldSel));
        checkOutput("stall_last", 32'(strm.o_last), 32'(heldLast));
      end
      if (ramRe) begin
        if (addrQ.size() == 0) checkOutput("unexpected_read", 32'(ramAddr), 32'hFFFF_FFFF);
        else checkOutput("ram_addr", 32'(ramAddr), 32'(addrQ.pop_front()));
      end
      if (strm.o_valid && strm.i_ready) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_word", strm.o_data, 32'hFFFF_FFFF);
        end else begin
          w = expQ.pop_front();
          checkOutput("word_data", strm.o_data, w.data);
          checkOutput("word_sel", 32'(strm.o_sel), 32'(w.sel));
          checkOutput("word_last", 32'(strm.o_last), 32'(w.last));
        end
        hsCount++;
      end
      checkOutput("fifo_cnt_le2", 32'(dut.cnt_q > 2'd2), 32'd0);
      held     = strm.o_valid && !strm.i_ready;
      heldData = strm.o_data;
      heldSel  = strm.o_sel;
      heldLast = strm.o_last;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    // Expected per-cycle outputs of test 1, counted from the cycle after the start edge.
    logic t1Valid [8] = '{0, 0, 1, 1, 1, 1, 0, 0};
    logic t1Re    [8] = '{1, 1, 1, 1, 0, 0, 0, 0};
    logic t1Done  [8] = '{0, 0, 0, 0, 0, 0, 1, 0};
    logic t1Busy  [8] = '{1, 1, 1, 1, 1, 1, 0, 0};
    int   base;

    for (int i = 0; i < 16; i++) mem[i] = 32'(i) * 32'h11;
    rst_n = 1'b0; start = 1'b0; baseAddr = '0; len = '0; strm.i_ready = 1'b1;

    repeat (2) @(negedge clk);
    checkOutput("reset_valid", 32'(strm.o_valid), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_re", 32'(ramRe), 32'd0);
    checkOutput("reset_data", strm.o_data, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    $display("[TB] test 1: base=3 len=4");
    expectTransfer(4'd3, 4);
    applyStimulus(4'd3, 5'd4);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checkOutput($sformatf("t1_valid_c%0d", c + 1), 32'(strm.o_valid), 32'(t1Valid[c]));
      checkOutput($sformatf("t1_re_c%0d", c + 1), 32'(ramRe), 32'(t1Re[c]));
      checkOutput($sformatf("t1_done_c%0d", c + 1), 32'(done), 32'(t1Done[c]));
      checkOutput($sformatf("t1_busy_c%0d", c + 1), 32'(busy), 32'(t1Busy[c]));
    end
    checkOutput("t1_words_left", 32'(expQ.size()), 32'd0);

    $display("[TB] test 2: base=0 len=8 with stall");
    expectTransfer(4'd0, 8);
    base = hsCount;
    applyStimulus(4'd0, 5'd8);
    for (int n = 0; n < 50 && hsCount < base + 2; n++) begin
      @(posedge clk); #1;
    end
    checkOutput("t2_two_words", 32'(hsCount - base), 32'd2);
    strm.i_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checkOutput("t2_stall_re", 32'(ramRe), 32'd0);
    end
    checkOutput("t2_stall_cnt", 32'(dut.cnt_q), 32'd2);
    repeat (3) @(posedge clk);
    #1 strm.i_ready = 1'b1;
    waitDone("t2", 60);
    checkOutput("t2_word_count", 32'(hsCount - base), 32'd8);

    $display("[TB] test 3: base=14 len=4 wrap");
    expectTransfer(4'd14, 4);
    applyStimulus(4'd14, 5'd4);
    waitDone("t3", 40);

    $display("[TB] test 4: len=0");
    applyStimulus(4'd7, 5'd0);
    @(negedge clk);
    checkOutput("t4_done", 32'(done), 32'd1);
    checkOutput("t4_valid", 32'(strm.o_valid), 32'd0);
    checkOutput("t4_re", 32'(ramRe), 32'd0);
    checkOutput("t4_busy", 32'(busy), 32'd0);
    @(negedge clk);
    checkOutput("t4_done_one_cycle", 32'(done), 32'd0);

    $display("[TB] test 5: len=16 sel wrap, ignored start");
    expectTransfer(4'd0, 16);
    applyStimulus(4'd0, 5'd16);
    repeat (5) @(posedge clk);
    #1 start = 1'b1; baseAddr = 4'd5; len = 5'd2;
    @(posedge clk); #1 start = 1'b0;
    waitDone("t5", 80);
    repeat (6) @(negedge clk);
    checkOutput("t5_idle_after", 32'(busy), 32'd0);

    $display("[TB] test 6: reset mid-transfer");
    expectTransfer(4'd0, 8);
    base = hsCount;
    applyStimulus(4'd0, 5'd8);
    for (int n = 0; n < 50 && hsCount < base + 3; n++) begin
      @(posedge clk); #1;
    end
    checkOutput("t6_three_words", 32'(hsCount - base), 32'd3);
    rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_valid", 32'(strm.o_valid), 32'd0);
    checkOutput("t6_rst_busy", 32'(busy), 32'd0);
    checkOutput("t6_rst_re", 32'(ramRe), 32'd0);
    checkOutput("t6_rst_done", 32'(done), 32'd0);
    checkOutput("t6_rst_last", 32'(strm.o_last), 32'd0);
    expQ.delete();
    addrQ.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checkOutput("t6_no_done", 32'(done), 32'd0);
      checkOutput("t6_idle", 32'(busy), 32'd0);
    end
    expectTransfer(4'd5, 2);
    applyStimulus(4'd5, 5'd2);
    waitDone("t6", 30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
